sdram_pixel_unpacker: RTL and testbench

- Read-side counterpart of the frame-buffer write packer.
- Pops paired 16-bit words from the two SDRAM read FIFOs on display pixel requests and unpacks them into 10-bit R/G/B.
- Substitutes a fill colour on FIFO underflow or outside an active frame.
- Sits between the SDRAM read-port FIFOs and the LCD/VGA timing controller.

---
 rtl/sdram_pixel_pkg.sv | 34 +++
 rtl/pixel_word_unpack.sv | 21 ++
 rtl/sdram_pixel_unpacker.sv | 125 ++++++++++++
 tb/tb_sdram_pixel_unpacker.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pixel_pkg.sv
// Shared definitions for the SDRAM pixel packer/unpacker pair: packed-word
// field positions, pixel widths, the frame state enum and the word-pair unpack helper.
package sdram_pixel_pkg;

  localparam int PIX_W    = 10;
  localparam int WORD_W   = 16;
  localparam int RGB_W    = 3 * PIX_W;
  localparam int PAD_BIT  = 15;
  localparam int G_HI_MSB = 14;
  localparam int G_HI_LSB = 10;
  localparam int BR_MSB   = 9;
  localparam int BR_LSB   = 0;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  typedef struct packed {
    logic [PIX_W-1:0] r;
    logic [PIX_W-1:0] g;
    logic [PIX_W-1:0] b;
  } rgb_t;

  // Word 1 carries {G[9:5], B}, word 2 carries {G[4:0], R}; the pad bit is stripped by the caller.
  function automatic rgb_t unpack_pair(input logic [PAD_BIT-1:0] w1, input logic [PAD_BIT-1:0] w2);
    rgb_t p;
    p.r = w2[BR_MSB:BR_LSB];
    p.g = {w1[G_HI_MSB:G_HI_LSB], w2[G_HI_MSB:G_HI_LSB]};
    p.b = w1[BR_MSB:BR_LSB];
    return p;
  endfunction

endpackage

// File: rtl/pixel_word_unpack.sv
// Combinational unpack of one FIFO word pair into {R,G,B}, with the fill
// colour substituted when no word was popped for this pixel.
module pixel_word_unpack
  import sdram_pixel_pkg::*;
#(
  parameter logic [29:0] FILL_RGB = 30'h0
) (
  input  logic [15:0] rd1_word,
  input  logic [15:0] rd2_word,
  input  logic        popped,
  output logic [29:0] pixel
);

  logic [RGB_W-1:0] unpacked;
  logic             unused_pad;

  assign unpacked   = unpack_pair(rd1_word[PAD_BIT-1:0], rd2_word[PAD_BIT-1:0]);
  assign unused_pad = rd1_word[PAD_BIT] ^ rd2_word[PAD_BIT];
  assign pixel      = popped ? unpacked : FILL_RGB;

endmodule

// File: rtl/sdram_pixel_unpacker.sv
// Read-side pixel unpacker: pops SDRAM read FIFO word pairs on display requests.
// Optional build macro SDRAM_PIXEL_UNPACKER_UNDERFLOW_COUNT_EN adds oUnderflow_count.
module sdram_pixel_unpacker
  import sdram_pixel_pkg::*;
#(
  parameter int          H_ACTIVE = 640,
  parameter int          V_ACTIVE = 480,
  parameter logic [29:0] FILL_RGB = 30'h0
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iFrame_start,
  input  logic        iRead_req,
  input  logic [15:0] iRd1_data,
  input  logic [15:0] iRd2_data,
  input  logic        iRd_empty,
  output logic        oRd_req,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic        oPix_valid,
  output logic        oUnderflow,
  output logic        oFrame_done
`ifdef SDRAM_PIXEL_UNPACKER_UNDERFLOW_COUNT_EN
  ,
  output logic [15:0] oUnderflow_count
`endif
);

  localparam int TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(TOTAL - 1);

  state_t           state;
  logic [CNT_W-1:0] pix_count;
  logic [CNT_W-1:0] cur_count;
  logic             req_q;
  logic             popped_q;
  logic             serve;
  logic             pop;
  logic             underflow;
  logic             last_pix;
  logic [RGB_W-1:0] pixel;

  // A frame start in the same cycle as a request makes that request pixel 0.
  assign serve     = iRead_req && (iFrame_start || (state == ACTIVE));
  assign cur_count = iFrame_start ? '0 : pix_count;
  assign pop       = serve && !iRd_empty;
  assign underflow = serve && iRd_empty;
  assign last_pix  = serve && (cur_count == LAST_PIX);
  assign oRd_req   = iRst_n && pop;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state       <= IDLE;
      pix_count   <= '0;
      req_q       <= 1'b0;
      popped_q    <= 1'b0;
      oUnderflow  <= 1'b0;
      oFrame_done <= 1'b0;
    end else begin
      req_q       <= iRead_req;
      popped_q    <= pop;
      oFrame_done <= last_pix;
      if (serve) begin
        if (last_pix) begin
          state     <= IDLE;
          pix_count <= cur_count;
        end else begin
          state     <= ACTIVE;
          pix_count <= cur_count + 1'b1;
        end
      end else if (iFrame_start) begin
        state     <= ACTIVE;
        pix_count <= '0;
      end
      if (underflow) begin
        oUnderflow <= 1'b1;
      end else if (iFrame_start) begin
        oUnderflow <= 1'b0;
      end
    end
  end

  pixel_word_unpack #(
    .FILL_RGB(FILL_RGB)
  ) u_unpack (
    .rd1_word(iRd1_data),
    .rd2_word(iRd2_data),
    .popped  (popped_q),
    .pixel   (pixel)
  );

  // FIFO data is valid the cycle after the pop, so the pixel registers one cycle later.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oPix_valid <= 1'b0;
      oRed       <= '0;
      oGreen     <= '0;
      oBlue      <= '0;
    end else begin
      oPix_valid <= req_q;
      if (req_q) begin
        {oRed, oGreen, oBlue} <= pixel;
      end
    end
  end

`ifdef SDRAM_PIXEL_UNPACKER_UNDERFLOW_COUNT_EN
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      oUnderflow_count <= '0;
    end else if (underflow) begin
      if (iFrame_start) begin
        oUnderflow_count <= 16'd1;
      end else if (oUnderflow_count != 16'hFFFF) begin
        oUnderflow_count <= oUnderflow_count + 16'd1;
      end
    end else if (iFrame_start) begin
      oUnderflow_count <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_pixel_unpacker.sv
// Self-checking bench for sdram_pixel_unpacker: directed vector table, hand
// sequences for frame end / reset, and randomized traffic against a reference model.
module tb_sdram_pixel_unpacker;

  localparam int          H = 4;
  localparam int          V = 2;
  localparam int          TOTAL = H * V;
  localparam logic [9:0]  FILL_R = 10'h155;
  localparam logic [9:0]  FILL_G = 10'h0AA;
  localparam logic [9:0]  FILL_B = 10'h30F;
  localparam logic [29:0] FILL = {FILL_R, FILL_G, FILL_B};

  logic        clk;
  logic        iRst_n;
  logic        iFrame_start;
  logic        iRead_req;
  logic [15:0] iRd1_data;
  logic [15:0] iRd2_data;
  logic        iRd_empty;
  logic        oRd_req;
  logic [9:0]  oRed;
  logic [9:0]  oGreen;
  logic [9:0]  oBlue;
  logic        oPix_valid;
  logic        oUnderflow;
  logic        oFrame_done;
`ifdef SDRAM_PIXEL_UNPACKER_UNDERFLOW_COUNT_EN
  logic [15:0] oUnderflow_count;
`endif

  sdram_pixel_unpacker #(
    .H_ACTIVE(H),
    .V_ACTIVE(V),
    .FILL_RGB(FILL)
  ) dut (
    .iClk        (clk),
    .iRst_n      (iRst_n),
    .iFrame_start(iFrame_start),
    .iRead_req   (iRead_req),
    .iRd1_data   (iRd1_data),
    .iRd2_data   (iRd2_data),
    .iRd_empty   (iRd_empty),
    .oRd_req     (oRd_req),
    .oRed        (oRed),
    .oGreen      (oGreen),
    .oBlue       (oBlue),
    .oPix_valid  (oPix_valid),
    .oUnderflow  (oUnderflow),
    .oFrame_done (oFrame_done)
`ifdef SDRAM_PIXEL_UNPACKER_UNDERFLOW_COUNT_EN
    ,
    .oUnderflow_count(oUnderflow_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] w1;
    logic [15:0] w2;
  } pair_t;

  typedef struct packed {
    logic [31:0] due;
    logic [29:0] rgb;
  } exp_t;

  typedef struct {
    logic        fs;
    logic        rq;
    logic        fe;
    logic [15:0] w1;
    logic [15:0] w2;
    logic        exp_pop;
    logic [9:0]  exp_r;
    logic [9:0]  exp_g;
    logic [9:0]  exp_b;
  } vec_t;

  pair_t fifo[$];
  exp_t  expq[$];
  vec_t  vecs[11];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cyc = -1;
  bit m_active = 0;
  int m_pix = 0;
  bit m_under = 0;
  int m_ucnt = 0;

  // Pixel from a word pair using plain field arithmetic; bit 15 falls out of the % 32.
  function automatic logic [29:0] modelPixel(input int w1, input int w2);
    int r, g, b;
    r = w2 % 1024;
    b = w1 % 1024;
    g = ((w1 / 1024) % 32) * 32 + ((w2 / 1024) % 32);
    return {r[9:0], g[9:0], b[9:0]};
  endfunction

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
    end
  endtask

  // Compares the registered outputs right after a clock edge with the model.
  task automatic checkOutput();
    logic        exp_valid;
    logic [29:0] exp_rgb;
    exp_t        e;
    exp_valid = 1'b0;
    exp_rgb   = '0;
    if (expq.size() > 0 && int'(expq[0].due) == cyc) begin
      e         = expq.pop_front();
      exp_valid = 1'b1;
      exp_rgb   = e.rgb;
    end
    checkValue("pix_valid", {31'b0, oPix_valid}, {31'b0, exp_valid});
    if (exp_valid) checkValue("pixel", {2'b0, oRed, oGreen, oBlue}, {2'b0, exp_rgb});
    checkValue("underflow", {31'b0, oUnderflow}, {31'b0, m_under});
    checkValue("frame_done", {31'b0, oFrame_done}, {31'b0, done_cyc == cyc});
`ifdef SDRAM_PIXEL_UNPACKER_UNDERFLOW_COUNT_EN
    checkValue("underflow_count", {16'b0, oUnderflow_count}, m_ucnt);
`endif
  endtask

  // One clock of stimulus; table vectors supply their own pop/pixel expectations.
  task automatic applyStimulus(input logic fs, input logic rq, input logic fe,
                               input logic use_tab, input logic tab_pop, input logic [29:0] tab_rgb);
    logic        serving;
    logic        model_pop;
    logic        exp_pop;
    logic [29:0] exp_rgb;
    exp_t        e;
    pair_t       p;
    @(negedge clk);
    iFrame_start = fs;
    iRead_req    = rq;
    iRd_empty    = fe || (fifo.size() == 0);
    #1;
    if (fs) begin
      m_active = 1;
      m_pix    = 0;
      m_under  = 0;
      m_ucnt   = 0;
    end
    serving   = rq && m_active;
    model_pop = serving && !iRd_empty;
    exp_pop   = model_pop;
    exp_rgb   = model_pop ? modelPixel(int'(fifo[0].w1), int'(fifo[0].w2)) : FILL;
    if (use_tab) begin
      exp_pop = tab_pop;
      exp_rgb = tab_rgb;
    end
    checkValue("rd_req", {31'b0, oRd_req}, {31'b0, exp_pop});
    if (rq) begin
      e.due = 32'(cyc + 2);
      e.rgb = exp_rgb;
      expq.push_back(e);
    end
    if (serving) begin
      if (iRd_empty) begin
        m_under = 1;
        if (m_ucnt < 65535) m_ucnt++;
      end
      m_pix++;
      if (m_pix == TOTAL) begin
        m_active = 0;
        done_cyc = cyc + 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
    iFrame_start = 1'b0;
    iRead_req    = 1'b0;
    if (model_pop) begin
      p         = fifo.pop_front();
      iRd1_data = p.w1;
      iRd2_data = p.w2;
    end
    checkOutput();
  endtask

  // Async reset in the middle of a burst: outputs must clear without waiting for a clock.
  task automatic resetMidBurst();
    #2;
    iRst_n    = 1'b0;
    iRead_req = 1'b1;
    iRd_empty = 1'b0;
    #1;
    checkValue("rst_pix_valid", {31'b0, oPix_valid}, 32'd0);
    checkValue("rst_pixel", {2'b0, oRed, oGreen, oBlue}, 32'd0);
    checkValue("rst_underflow", {31'b0, oUnderflow}, 32'd0);
    checkValue("rst_frame_done", {31'b0, oFrame_done}, 32'd0);
    checkValue("rst_rd_req", {31'b0, oRd_req}, 32'd0);
    expq.delete();
    m_active = 0;
    m_pix    = 0;
    m_under  = 0;
    m_ucnt   = 0;
    done_cyc = -1;
    @(posedge clk);
    cyc++;
    #1;
    iRst_n    = 1'b1;
    iRead_req = 1'b0;
  endtask

  task automatic pushRandomPair();
    pair_t p;
    p.w1 = 16'($urandom);
    p.w2 = 16'($urandom);
    fifo.push_back(p);
  endtask

  initial begin
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h7FC3, 16'h7C00, 1'b1, 10'h000, 10'h3FF, 10'h3C3};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h043C, 16'h703C, 1'b1, 10'h03C, 10'h03C, 10'h03C};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, FILL_R, FILL_G, FILL_B};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 10'h3FF, 10'h3FF, 10'h3FF};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0, FILL_R, FILL_G, FILL_B};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 16'h1234, 16'h5678, 1'b1, 10'h278, 10'h095, 10'h234};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0001, 16'h0002, 1'b1, 10'h002, 10'h000, 10'h001};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0400, 16'h0400, 1'b1, 10'h000, 10'h021, 10'h000};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h03FF, 16'h7C00, 1'b1, 10'h000, 10'h01F, 10'h3FF};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0555, 16'h0AAA, 1'b0, FILL_R, FILL_G, FILL_B};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 16'h2AAA, 16'h1555, 1'b1, 10'h155, 10'h145, 10'h2AA};

    iRst_n       = 1'b0;
    iFrame_start = 1'b0;
    iRead_req    = 1'b1;
    iRd_empty    = 1'b0;
    iRd1_data    = '0;
    iRd2_data    = '0;
    #2;
    checkValue("reset_pix_valid", {31'b0, oPix_valid}, 32'd0);
    checkValue("reset_pixel", {2'b0, oRed, oGreen, oBlue}, 32'd0);
    checkValue("reset_underflow", {31'b0, oUnderflow}, 32'd0);
    checkValue("reset_frame_done", {31'b0, oFrame_done}, 32'd0);
    checkValue("reset_rd_req", {31'b0, oRd_req}, 32'd0);
`ifdef SDRAM_PIXEL_UNPACKER_UNDERFLOW_COUNT_EN
    checkValue("reset_underflow_count", {16'b0, oUnderflow_count}, 32'd0);
`endif
    @(posedge clk);
    #1;
    iRst_n    = 1'b1;
    iRead_req = 1'b0;

    // Directed frame: unpack patterns, an underflow on pixel 2, frame end, idle fill, restart.
    $display("[TB] directed vector table");
    for (int i = 0; i < 11; i++) begin
      if (vecs[i].fs) fifo.delete();
      if (!vecs[i].fe) fifo.push_back({vecs[i].w1, vecs[i].w2});
      applyStimulus(vecs[i].fs, vecs[i].rq, vecs[i].fe, 1'b1, vecs[i].exp_pop,
                    {vecs[i].exp_r, vecs[i].exp_g, vecs[i].exp_b});
    end

    // Frame restarted with pixel 0 already taken: seven more requests must end it.
    $display("[TB] remaining pixels of restarted frame");
    for (int i = 0; i < 7; i++) pushRandomPair();
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Reset in the middle of a burst, then requests with no frame start.
    $display("[TB] reset mid-burst");
    fifo.delete();
    for (int i = 0; i < 4; i++) pushRandomPair();
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    resetMidBurst();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

    $display("[TB] randomized traffic");
    fifo.delete();
    for (int i = 0; i < 600; i++) begin
      logic fs, rq, fe;
      if (fifo.size() < 4 && $urandom_range(0, 3) != 0) pushRandomPair();
      fs = (!m_active && $urandom_range(0, 4) == 0) || ($urandom_range(0, 59) == 0);
      rq = ($urandom_range(0, 3) != 0);
      fe = ($urandom_range(0, 7) == 0);
      if (fs) fifo.delete();
      applyStimulus(fs, rq, fe, 1'b0, 1'b0, '0);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
